// File: rtl/uart_pkg.sv
// Shared UART definitions: line state encoding, oversampling default, idle level.
// The TX and RX sides both step through this state encoding.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam logic        LINE_IDLE      = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Counter width that is never zero, so n=1 still yields a legal vector.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud_tick strobes and flags the tick that completes a bit period.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int unsigned TICKS = OVERSAMPLE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic tick,
   output logic bit_end_c
);

   localparam int unsigned CNT_W = cnt_width(TICKS);

   logic [CNT_W-1:0] tick_cnt;

   assign bit_end_c = tick && !clear && (tick_cnt == CNT_W'(TICKS - 1));

   // Wraps to zero on the last tick of a bit so the next bit starts clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (clear || bit_end_c) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_32_bit_tx.sv
// UART transmitter: one word per handshake, framed as start, LSB-first data, stop bits.
// All outputs are registered from next-state values, so nothing combinational reaches tx or done.
module uart_32_bit_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  baud_tick,
   input  logic                  tx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_ready,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned IDX_W  = cnt_width(DATA_WIDTH);
   localparam int unsigned STOP_W = cnt_width(STOP_BITS);

   uart_state_t           state, state_nxt;
   logic [DATA_WIDTH-1:0] shift, shift_nxt;
   logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
   logic [STOP_W-1:0]     stop_cnt, stop_cnt_nxt;
   logic                  tx_nxt, ready_nxt, busy_nxt, done_nxt;
   logic                  accept_c, bit_end_c, timer_clear_c;

   assign accept_c      = tx_valid && tx_ready;
   assign timer_clear_c = (state == IDLE);

   uart_bit_timer #(
      .TICKS (OVERSAMPLE)
   ) u_bit_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (timer_clear_c),
      .tick      (baud_tick),
      .bit_end_c (bit_end_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         shift    <= '0;
         bit_idx  <= '0;
         stop_cnt <= '0;
         tx       <= LINE_IDLE;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         shift    <= shift_nxt;
         bit_idx  <= bit_idx_nxt;
         stop_cnt <= stop_cnt_nxt;
         tx       <= tx_nxt;
         tx_ready <= ready_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      shift_nxt    = shift;
      bit_idx_nxt  = bit_idx;
      stop_cnt_nxt = stop_cnt;
      done_nxt     = 1'b0;
      tx_nxt       = LINE_IDLE;

      case (state)
         IDLE: begin
            if (accept_c) begin
               state_nxt = START;
               shift_nxt = tx_data;
            end
         end
         START: begin
            if (bit_end_c) begin
               state_nxt   = DATA;
               bit_idx_nxt = '0;
            end
         end
         DATA: begin
            if (bit_end_c) begin
               shift_nxt = shift >> 1;
               if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                  state_nxt    = STOP;
                  stop_cnt_nxt = '0;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end
         end
         STOP: begin
            if (bit_end_c) begin
               if (stop_cnt == STOP_W'(STOP_BITS - 1)) begin
                  state_nxt    = IDLE;
                  stop_cnt_nxt = '0;
                  done_nxt     = 1'b1;
               end else begin
                  stop_cnt_nxt = stop_cnt + STOP_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
         default: tx_nxt = LINE_IDLE;
      endcase

      // Ready is withheld during the done cycle so done and an accept never coincide.
      busy_nxt  = (state_nxt != IDLE);
      ready_nxt = (state_nxt == IDLE) && !done_nxt;
   end

endmodule
